// File: rtl/bit_count_engine.sv
// Ones/zeros counter with its own start/done controller; consumes STEP bits of
// the working register per cycle and stops as soon as no set bits remain.
module bit_count_engine #(
  parameter  int WIDTH = 8,
  parameter  int STEP  = 1,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] A,
  output logic             ready,
  output logic             done,
  output logic [CNT_W-1:0] result
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] w_reg, w_next;
  logic [CNT_W-1:0] c_reg, c_next;
  logic [CNT_W-1:0] slice_pop;

  always_comb begin
    slice_pop = '0;
    for (int i = 0; i < STEP; i++) begin
      slice_pop = slice_pop + CNT_W'(w_reg[i]);
    end
  end

  always_comb begin
    state_next = state_reg;
    w_next     = w_reg;
    c_next     = c_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          // Zeros mode inverts at load so the run loop is mode-agnostic.
          w_next     = mode ? ~A : A;
          c_next     = '0;
          state_next = RUN;
        end
      end
      RUN: begin
        if (w_reg == '0) begin
          state_next = DONE;
        end else begin
          c_next = c_reg + slice_pop;
          w_next = w_reg >> STEP;
        end
      end
      DONE: begin
        if (!start) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= IDLE;
      w_reg     <= '0;
      c_reg     <= '0;
    end else begin
      state_reg <= state_next;
      w_reg     <= w_next;
      c_reg     <= c_next;
    end
  end

  assign ready  = (state_reg == IDLE);
  assign done   = (state_reg == DONE);
  assign result = c_reg;

endmodule

// File: doc/bit_count_engine.md
# bit_count_engine

Parametrised ones/zeros counter with its own controller and start/done handshake. It counts the set bits (or clear bits) of a WIDTH-bit operand, processing STEP bits per clock. The engine terminates early once no set bits remain in the working register. It replaces the separate controller/datapath bit counter and is used standalone or behind a switch/button front end.

## Interface
- WIDTH, 8, operand width in bits; WIDTH >= 1
- STEP, 1, bits consumed per RUN cycle; 1 <= STEP <= WIDTH, and WIDTH % STEP == 0
- CNT_W, $clog2(WIDTH+1), result width (derived, not overridden)

- clk  input  1  rising-edge clock; the only clock
- reset_n  input  1  asynchronous, active-low reset
- start  input  1  request; sampled only in IDLE and DONE
- mode  input  1  0 = count ones of A, 1 = count zeros of A; sampled with A at load
- A  input  WIDTH  operand; sampled at load only
- ready  output  1  high in IDLE
- done  output  1  high in DONE
- result  output  CNT_W  count; valid while done=1, retained in IDLE until next load

## Operation
- Internal state: working register W (WIDTH), accumulator C (CNT_W), FSM state.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - ready=1, done=0.
  - If start=1 at a clock edge: W <= (mode ? ~A : A), C <= 0, go to RUN.
  - Otherwise hold W, C, and state.
- RUN:
  - ready=0, done=0.
  - If W == 0: go to DONE; C unchanged.
  - Else: C <= C + popcount(W[STEP-1:0]) and W <= W >> STEP (logical shift, zero fill); stay in RUN.
  - start, mode, and A are ignored in this state.
- DONE:
  - ready=0, done=1, result=C.
  - Stay in DONE while start=1.
  - Go to IDLE when start=0. C is held, so result persists in IDLE.
- Zeros mode works by inverting the operand at load; the early-termination logic is identical for both modes.
- Arithmetic: C never exceeds WIDTH, so there is no overflow. popcount of a STEP-bit slice is zero-extended to CNT_W.
- result is driven directly from C in all states.

## Timing
- Reset (reset_n=0, asynchronous, takes effect immediately): state=IDLE, W=0, C=0.
  - Output values during and after reset: ready=1, done=0, result=0.
- Reset asserted mid-RUN or in DONE aborts immediately. No partial result survives.
- Let h = index of the highest 1 in the loaded W, and k = ceil((h+1)/STEP); k = 0 if W = 0.
- Load happens at edge t. RUN occupies edges t+1 through t+k+1. done rises after edge t+k+1.
  - Latency from load edge to done is k+1 cycles.
  - Minimum latency is 1 cycle (W = 0). Maximum is WIDTH/STEP + 1 cycles.
- ready falls after the load edge and rises after the edge on which DONE sees start=0.
- If start stays high through DONE, the engine does not restart. start must be seen low in DONE, then high again in IDLE.
  - Minimum period between back-to-back operations: load, RUN, DONE (1 cycle with start=0), then IDLE (1 cycle with start=1).
- Changes to A or mode after the load edge have no effect on the current operation.

## Test plan
- WIDTH=8, STEP=1, mode=0, A=0x03, start pulsed 1 cycle:
  - done rises 3 cycles after the load edge, result=2.
  - A changed to 0xFF mid-RUN has no effect.
- WIDTH=8, STEP=1, mode=0, A=0x1F:
  - result=5, done after 6 cycles.
  - Then start held high through DONE: done stays 1 and no reload occurs.
  - Drop start: ready=1 next cycle and result still 5.
- WIDTH=8, STEP=1, mode=0, A=0x00: done after 1 cycle, result=0.
- WIDTH=8, STEP=1, mode=0, A=0x80: result=1 after 9 cycles (maximum latency).
- WIDTH=8, STEP=1, mode=1, A=0x03:
  - Loaded W=0xFC, result=6 after 9 cycles.
- WIDTH=8, STEP=2, mode=0:
  - A=0xFF: result=8 after 5 cycles.
  - A=0x03: result=2 after 2 cycles.
- Any config, reset_n pulsed low mid-RUN:
  - Immediately ready=1, done=0, result=0.
  - A new start after reset completes normally.
